// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: verifies line/frame timing against the configured
// mode, locks onto the frame and recovers active-area coordinates, colour and a valid strobe.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       sclk,
  input  logic       srst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic       locked,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic       err_hline,
  output logic       err_vframe
);

  localparam int unsigned CW      = 12;
  localparam int unsigned CW1     = 13;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
  localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_hs;
  logic          r_hs_d;
  logic          r_vs;
  logic          r_vs_at_hs;
  logic          r_h_seen;
  logic [2:0]    r_rgb;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;

  logic          w_hs_edge;
  logic          w_vs_start;
  logic          w_line_bad;
  logic          w_frame_bad;
  logic          w_err_h;
  logic          w_err_v;
  logic          w_lock_nxt;
  logic          w_active;
  logic          w_valid;
  logic [CW-1:0] w_hcnt_inc;
  logic [CW-1:0] w_vcnt_inc;
  logic [CW-1:0] w_hcnt_nxt;
  logic [CW-1:0] w_vcnt_nxt;
  logic [9:0]    w_x;
  logic [9:0]    w_y;

  // Counters give the position of the pixel now in stage 1; the outputs register it.
  always_comb begin
    w_hs_edge   = (r_hs == SYNC_POL) && (r_hs_d != SYNC_POL);
    w_vs_start  = w_hs_edge && (r_vs == SYNC_POL) && !r_vs_at_hs;
    w_hcnt_inc  = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CW'(1);
    w_vcnt_inc  = (r_vcnt == CNT_MAX) ? r_vcnt : r_vcnt + CW'(1);
    w_hcnt_nxt  = w_hs_edge ? '0 : w_hcnt_inc;
    w_vcnt_nxt  = w_vs_start ? '0 : (w_hs_edge ? w_vcnt_inc : r_vcnt);
    w_line_bad  = w_hs_edge && r_h_seen &&
                  (({1'b0, r_hcnt} + CW1'(1)) != CW1'(H_TOTAL));
    w_frame_bad = w_vs_start && (({1'b0, r_vcnt} + CW1'(1)) != CW1'(V_TOTAL));
    w_err_h     = (r_state != SEARCH) && w_line_bad;
    w_err_v     = (r_state != SEARCH) && w_frame_bad;
    w_lock_nxt  = !(w_err_h || w_err_v) &&
                  ((r_state == LOCKED) || ((r_state == ACQUIRE) && w_vs_start));
    w_active    = (w_hcnt_nxt >= CW'(H_ACT0)) && (w_hcnt_nxt < CW'(H_ACT0 + H_VISIBLE)) &&
                  (w_vcnt_nxt >= CW'(V_ACT0)) && (w_vcnt_nxt < CW'(V_ACT0 + V_VISIBLE));
    w_valid     = w_lock_nxt && w_active;
    w_x         = 10'(w_hcnt_nxt - CW'(H_ACT0));
    w_y         = 10'(w_vcnt_nxt - CW'(V_ACT0));
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_state     <= SEARCH;
      r_hs        <= ~SYNC_POL;
      r_hs_d      <= ~SYNC_POL;
      r_vs        <= ~SYNC_POL;
      r_vs_at_hs  <= 1'b0;
      r_h_seen    <= 1'b0;
      r_rgb       <= '0;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      err_hline   <= 1'b0;
      err_vframe  <= 1'b0;
    end else if (pix_en) begin
      r_hs   <= hsync;
      r_hs_d <= r_hs;
      r_vs   <= vsync;
      r_rgb  <= {r, g, b};
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      if (w_hs_edge) begin
        r_vs_at_hs <= (r_vs == SYNC_POL);
        r_h_seen   <= 1'b1;
      end

      // Any timing error drops straight back to SEARCH, even on a vs_start cycle.
      case (r_state)
        SEARCH: begin
          if (w_vs_start) r_state <= ACQUIRE;
        end
        ACQUIRE: begin
          if (w_err_h || w_err_v) r_state <= SEARCH;
          else if (w_vs_start)    r_state <= LOCKED;
        end
        LOCKED: begin
          if (w_err_h || w_err_v) r_state <= SEARCH;
        end
        default: r_state <= SEARCH;
      endcase

      locked      <= w_lock_nxt;
      pix_valid   <= w_valid;
      pix_x       <= w_valid ? w_x : '0;
      pix_y       <= w_valid ? w_y : '0;
      pix_rgb     <= w_valid ? r_rgb : '0;
      frame_start <= w_valid && (w_x == '0) && (w_y == '0);
      err_hline   <= w_err_h;
      err_vframe  <= w_err_v;
    end
  end

endmodule
